// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - segment FIFO and back-to-back sequencer feeding the DDA step timer
module move_scheduler #(
    parameter int MOVE_DEPTH = 4,
    parameter int INCR_W     = 32,
    parameter int DUR_W      = 32,
    localparam int LW        = $clog2(MOVE_DEPTH) + 1,
    localparam int PW        = $clog2(MOVE_DEPTH)
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              enable,
    input  logic              abort,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [INCR_W-1:0] push_increment,
    input  logic              push_dir,
    input  logic [DUR_W-1:0]  push_duration,
    output logic              seg_active,
    output logic              seg_start,
    output logic              seg_done,
    output logic [INCR_W-1:0] seg_increment,
    output logic              seg_dir,
    output logic              underrun,
    output logic [LW-1:0]     queue_level,
    output logic [7:0]        done_count
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DUR_W-1:0]  remaining_q, remaining_d;
    logic              seg_active_q, seg_active_d;
    logic              seg_start_q, seg_start_d;
    logic              seg_done_q, seg_done_d;
    logic [INCR_W-1:0] seg_increment_q, seg_increment_d;
    logic              seg_dir_q, seg_dir_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        done_count_q, done_count_d;

    logic [INCR_W-1:0] inc_mem_q [MOVE_DEPTH];
    logic              dir_mem_q [MOVE_DEPTH];
    logic [DUR_W-1:0]  dur_mem_q [MOVE_DEPTH];

    logic              push_fire, wr_en, pop, can_pop;
    logic [DUR_W-1:0]  head_dur;

    assign push_ready = (level_q != LW'(MOVE_DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign wr_en      = push_fire && !abort;
    assign can_pop    = enable && (level_q != '0);
    assign head_dur   = dur_mem_q[rd_ptr_q];

    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        level_d         = level_q;
        remaining_d     = remaining_q;
        seg_active_d    = seg_active_q;
        seg_start_d     = 1'b0;
        seg_done_d      = 1'b0;
        seg_increment_d = seg_increment_q;
        seg_dir_d       = seg_dir_q;
        underrun_d      = 1'b0;
        done_count_d    = done_count_q;
        pop             = 1'b0;

        case (state_q)
            S_IDLE: pop = can_pop;
            S_RUN: begin
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - DUR_W'(1);
                end else begin
                    seg_done_d   = 1'b1;
                    done_count_d = done_count_q + 8'd1;
                    if (can_pop) begin
                        pop = 1'b1;
                    end else begin
                        state_d         = S_IDLE;
                        seg_active_d    = 1'b0;
                        seg_increment_d = '0;
                        underrun_d      = enable;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero duration still runs for one cycle, so the counter floors at 0.
        if (pop) begin
            state_d         = S_RUN;
            seg_active_d    = 1'b1;
            seg_start_d     = 1'b1;
            seg_increment_d = inc_mem_q[rd_ptr_q];
            seg_dir_d       = dir_mem_q[rd_ptr_q];
            remaining_d     = (head_dur == '0) ? '0 : head_dur - DUR_W'(1);
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push_fire, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (abort) begin
            state_d         = S_IDLE;
            rd_ptr_d        = '0;
            wr_ptr_d        = '0;
            level_d         = '0;
            remaining_d     = '0;
            seg_active_d    = 1'b0;
            seg_start_d     = 1'b0;
            seg_done_d      = 1'b0;
            seg_increment_d = '0;
            seg_dir_d       = seg_dir_q;
            underrun_d      = 1'b0;
            done_count_d    = done_count_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            level_q         <= '0;
            remaining_q     <= '0;
            seg_active_q    <= 1'b0;
            seg_start_q     <= 1'b0;
            seg_done_q      <= 1'b0;
            seg_increment_q <= '0;
            seg_dir_q       <= 1'b0;
            underrun_q      <= 1'b0;
            done_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            level_q         <= level_d;
            remaining_q     <= remaining_d;
            seg_active_q    <= seg_active_d;
            seg_start_q     <= seg_start_d;
            seg_done_q      <= seg_done_d;
            seg_increment_q <= seg_increment_d;
            seg_dir_q       <= seg_dir_d;
            underrun_q      <= underrun_d;
            done_count_q    <= done_count_d;
        end
    end

    // Storage needs no reset: level and pointers define which entries are valid.
    always_ff @(posedge CLK) begin
        if (resetn && wr_en) begin
            inc_mem_q[wr_ptr_q] <= push_increment;
            dir_mem_q[wr_ptr_q] <= push_dir;
            dur_mem_q[wr_ptr_q] <= push_duration;
        end
    end

    assign seg_active    = seg_active_q;
    assign seg_start     = seg_start_q;
    assign seg_done      = seg_done_q;
    assign seg_increment = seg_increment_q;
    assign seg_dir       = seg_dir_q;
    assign underrun      = underrun_q;
    assign queue_level   = level_q;
    assign done_count    = done_count_q;

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - randomized and directed bench for move_scheduler against a queue model
module tb_move_scheduler;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn, enable, abort, push_valid, push_dir;
    logic [31:0] push_increment, push_duration;
    logic        push_ready, seg_active, seg_start, seg_done, seg_dir, underrun;
    logic [31:0] seg_increment;
    logic [2:0]  queue_level;
    logic [7:0]  done_count;

    move_scheduler #(.MOVE_DEPTH(DEPTH), .INCR_W(32), .DUR_W(32)) dut (
        .CLK(clk), .resetn(resetn), .enable(enable), .abort(abort),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_increment(push_increment), .push_dir(push_dir), .push_duration(push_duration),
        .seg_active(seg_active), .seg_start(seg_start), .seg_done(seg_done),
        .seg_increment(seg_increment), .seg_dir(seg_dir), .underrun(underrun),
        .queue_level(queue_level), .done_count(done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inc;
        logic        dir;
        logic [31:0] dur;
    } seg_t;

    seg_t        mq[$];
    bit          m_active, m_start, m_done, m_und, m_dir;
    logic [31:0] m_inc;
    int          m_left, m_cnt;
    int          n_checks = 0, n_pass = 0;
    int          act_cnt, und_cnt, start_cnt, done_cnt, saved_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Segment-level reference: a queue of pending segments and a count of active cycles left.
    task automatic model_step();
        bit   can_pop, push_ok, load_now;
        seg_t s;
        if (!resetn) begin
            mq.delete();
            m_active = 0; m_inc = 0; m_dir = 0; m_left = 0; m_cnt = 0;
            m_start = 0; m_done = 0; m_und = 0;
            return;
        end
        if (abort) begin
            mq.delete();
            m_active = 0; m_inc = 0; m_left = 0;
            m_start = 0; m_done = 0; m_und = 0;
            return;
        end
        can_pop  = enable && mq.size() != 0;
        push_ok  = push_valid && mq.size() < DEPTH;
        m_start  = 0; m_done = 0; m_und = 0;
        load_now = 0;
        if (m_active) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_cnt  = (m_cnt + 1) % 256;
                if (can_pop) load_now = 1;
                else begin
                    m_active = 0; m_inc = 0; m_und = enable;
                end
            end
        end else begin
            load_now = can_pop;
        end
        if (load_now) begin
            s = mq.pop_front();
            m_active = 1; m_start = 1; m_inc = s.inc; m_dir = s.dir;
            m_left = (s.dur == 0) ? 1 : int'(s.dur);
        end
        if (push_ok) mq.push_back('{push_increment, push_dir, push_duration});
    endtask

    task automatic compare();
        check("seg_active", seg_active, m_active);
        check("seg_start", seg_start, m_start);
        check("seg_done", seg_done, m_done);
        check("seg_increment", seg_increment, m_inc);
        check("seg_dir", seg_dir, m_dir);
        check("underrun", underrun, m_und);
        check("queue_level", queue_level, mq.size());
        check("push_ready", push_ready, mq.size() != DEPTH);
        check("done_count", done_count, m_cnt);
        act_cnt   += seg_active;
        und_cnt   += underrun;
        start_cnt += seg_start;
        done_cnt  += seg_done;
    endtask

    task automatic cyc(input logic rn, input logic en, input logic ab, input logic pv,
                       input logic [31:0] inc, input logic d, input logic [31:0] dur);
        resetn = rn; enable = en; abort = ab; push_valid = pv;
        push_increment = inc; push_dir = d; push_duration = dur;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic push(input logic en, input logic [31:0] inc, input logic d, input logic [31:0] dur);
        cyc(1, en, 0, 1, inc, d, dur);
    endtask

    task automatic idle(input logic en, input int n);
        for (int i = 0; i < n; i++) cyc(1, en, 0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic clr_counts();
        act_cnt = 0; und_cnt = 0; start_cnt = 0; done_cnt = 0;
    endtask

    initial begin
        clr_counts();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h55, 1, 3);

        // Single segment
        clr_counts();
        push(1, 32'h100, 1, 5);
        idle(1, 8);
        check("t1_active_cycles", act_cnt, 5);
        check("t1_underruns", und_cnt, 1);
        check("t1_done_count", done_count, 1);

        // Chaining of 3, 1 and 4 cycle segments
        clr_counts();
        push(0, 32'h11, 0, 3);
        push(0, 32'h22, 1, 1);
        push(0, 32'h33, 0, 4);
        idle(1, 11);
        check("t2_active_cycles", act_cnt, 8);
        check("t2_starts", start_cnt, 3);
        check("t2_dones", done_cnt, 3);
        check("t2_underruns", und_cnt, 1);
        check("t2_done_count", done_count, 4);

        // Full queue and backpressure, then push while popping at full
        for (int i = 0; i < DEPTH + 2; i++) push(0, 32'h40 + i, i[0], 2);
        check("t3_level_full", queue_level, DEPTH);
        check("t3_ready_full", push_ready, 0);
        push(1, 32'hdead, 1, 2);
        check("t3_level_after_pop", queue_level, DEPTH - 1);
        idle(1, 12);

        // Zero duration, then enable gating mid-segment
        clr_counts();
        push(1, 32'h77, 1, 0);
        idle(1, 3);
        check("t4_zero_dur_cycles", act_cnt, 1);
        push(0, 32'h81, 0, 4);
        push(0, 32'h82, 1, 2);
        idle(1, 2);
        clr_counts();
        idle(0, 6);
        check("t4_no_underrun", und_cnt, 0);
        check("t4_no_reload", start_cnt, 0);
        idle(1, 5);

        // Abort during a run with two entries queued and a concurrent push
        push(0, 32'h91, 0, 6);
        push(0, 32'h92, 1, 3);
        push(0, 32'h93, 0, 3);
        idle(1, 2);
        saved_cnt = done_count;
        clr_counts();
        cyc(1, 1, 1, 1, 32'h94, 1, 2);
        check("t5_level", queue_level, 0);
        check("t5_active", seg_active, 0);
        check("t5_increment", seg_increment, 0);
        check("t5_done_count", done_count, saved_cnt);
        check("t5_no_done", done_cnt, 0);
        idle(1, 3);

        // Mid-run reset
        push(1, 32'ha5, 1, 10);
        idle(1, 3);
        cyc(0, 1, 1, 1, 32'ha6, 1, 2);
        check("t6_active", seg_active, 0);
        check("t6_dir", seg_dir, 0);
        check("t6_done_count", done_count, 0);

        // 256 one-cycle segments wrap the completion counter
        for (int i = 0; i < 256; i++) push(1, 32'h1000 + i, i[1], 1);
        idle(1, 4);
        check("t7_wrap", done_count, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)),
                $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
